// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring subtract-compare-shift for divide. Purely combinational.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   rem_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0]   rem_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             take;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // Trial remainder is WIDTH+1 bits; after a successful subtract it fits in WIDTH.
    shifted = {rem_in, acc_in[WIDTH-1]};
    take    = shifted >= {1'b0, operand};
    diff    = shifted[WIDTH-1:0] - operand;
    acc_out = acc_in;
    rem_out = rem_in;
    if (is_div) begin
      acc_out[WIDTH-1:0] = {acc_in[WIDTH-2:0], take};
      rem_out            = take ? diff : shifted[WIDTH-1:0];
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO registers.
// Define MULDIV_DIV0_EXC_EN to short-circuit divide-by-zero and raise div0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q, res_neg_q, rem_neg_q, busy_q, done_q;
  logic [WIDTH-1:0]   operand_q, rem_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix, rem_step;
  logic [2*WIDTH-1:0] acc_step, prod_fix;

  always_comb begin
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    op_div    = (op == MD_DIV) || (op == MD_DIVU);
    // The magnitude of the most negative value is still correct read as unsigned.
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    prod_fix  = res_neg_q ? -acc_q : acc_q;
    quo_fix   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? -rem_q : rem_q;
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div (is_div_q),
    .acc_in (acc_q),
    .rem_in (rem_q),
    .operand(operand_q),
    .acc_out(acc_step),
    .rem_out(rem_step)
  );

`ifdef MULDIV_DIV0_EXC_EN
  logic div0_q, skip_q;
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      operand_q <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV0_EXC_EN
      div0_q    <= 1'b0;
      skip_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV0_EXC_EN
      div0_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (hi_wr) hi_q <= wr_data;
          if (lo_wr) lo_q <= wr_data;
          if (start && !cancel) begin
            is_div_q  <= op_div;
            res_neg_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q <= op_signed && a[WIDTH-1];
            // Divide: divisor in operand, dividend shifts out of acc low half.
            // Multiply: multiplicand in operand, multiplier in acc low half.
            operand_q <= op_div ? b_mag : a_mag;
            acc_q     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          if (cancel) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
`ifdef MULDIV_DIV0_EXC_EN
          // Zero divisor is caught on the first CALC edge and bypasses the iterations.
          else if (is_div_q && operand_q == '0) begin
            cnt_q   <= '0;
            skip_q  <= 1'b1;
            state_q <= StFix;
          end
`endif
          else begin
            acc_q <= acc_step;
            rem_q <= rem_step;
            if (cnt_q == LastIter) begin
              cnt_q   <= '0;
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StFix: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
`ifdef MULDIV_DIV0_EXC_EN
          skip_q  <= 1'b0;
          if (!cancel) begin
            done_q <= 1'b1;
            div0_q <= skip_q;
          end
          if (!cancel && !skip_q) begin
`else
          if (!cancel) begin
            done_q <= 1'b1;
`endif
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors, queue-based result checking.
module tb_muldiv_unit;

  logic        clk, rst, start, cancel, hi_wr, lo_wr;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .hi_wr  (hi_wr),
    .lo_wr  (lo_wr),
    .wr_data(wr_data),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_hi", {32'h0, hi}, {32'h0, e.hi});
        check("result_lo", {32'h0, lo}, {32'h0, e.lo});
        check("result_div0", {63'h0, div0}, {63'h0, e.div0});
        check("result_latency", 64'(cyc), 64'(e.cyc));
        check("busy_at_done", {63'h0, busy}, 64'h0);
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start released.
  task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat);
    exp_t e;
    op = o;
    a = aa;
    b = bb;
    start = 1'b1;
    e.hi = eh;
    e.lo = el;
    e.div0 = ed;
    e.cyc = cyc + lat + 1;
    sb_q.push_back(e);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: done timeout, got 0, expected 1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_div0", {63'h0, div0}, 64'h0);
    check("reset_hi", {32'h0, hi}, 64'h0);
    check("reset_lo", {32'h0, lo}, 64'h0);

    // Chained back-to-back: each start lands in the previous done cycle.
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    wait_done("mult_neg3_7");
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    wait_done("multu_max");
    issue(2'b00, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
    wait_done("mult_minint_2");
    issue(2'b01, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000, 1'b0, 33);
    wait_done("multu_minint_2");
    issue(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E, 1'b0, 33);
    wait_done("mult_neg5_neg6");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    wait_done("div_neg7_2");
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    wait_done("divu_100_7");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    wait_done("div_minint_neg1");
`ifdef MULDIV_DIV0_EXC_EN
    issue(2'b11, 32'd5, 32'd0, m_hi, m_lo, 1'b1, 2);
`else
    issue(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 33);
`endif
    wait_done("divu_by_zero");
    @(negedge clk);

    // mthi, then a cancelled mult; moves and starts while busy are ignored.
    hi_wr = 1'b1;
    wr_data = 32'h0000_1234;
    @(negedge clk);
    hi_wr = 1'b0;
    m_hi = 32'h0000_1234;
    check("mthi_idle", {32'h0, hi}, {32'h0, m_hi});
    op = 2'b00;
    a = 32'd3;
    b = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hi_wr = 1'b1;
    wr_data = 32'h0000_DEAD;
    op = 2'b01;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    hi_wr = 1'b0;
    start = 1'b0;
    check("mthi_busy_ignored", {32'h0, hi}, {32'h0, m_hi});
    check("busy_in_calc", {63'h0, busy}, 64'h1);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'h0, busy}, 64'h0);
    check("cancel_hi", {32'h0, hi}, {32'h0, m_hi});
    check("cancel_lo", {32'h0, lo}, {32'h0, m_lo});
    repeat (40) @(negedge clk);
    check("cancel_stays_idle", {63'h0, busy}, 64'h0);

    // cancel suppresses a same-cycle start in IDLE
    op = 2'b00;
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b0;
    check("cancel_start_idle", {63'h0, busy}, 64'h0);
    repeat (36) @(negedge clk);

    // mtlo with start: move applies now, result overwrites at FIX
    lo_wr = 1'b1;
    wr_data = 32'h0000_0055;
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);
    lo_wr = 1'b0;
    check("mtlo_with_start", {32'h0, lo}, 64'h55);
    wait_done("mult_2_3");
    @(negedge clk);

    // Asynchronous reset mid-CALC
    issue(2'b01, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 33);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_div0", {63'h0, div0}, 64'h0);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 33);
    wait_done("mult_after_reset");
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core; executes mult, multu, div, divu and services mfhi/mflo/mthi/mtlo. Sits beside the ALU, launched from the core FSM's execute state; the core stalls on `busy`. Parametrised in operand width, one result bit per cycle, with sign handling for signed ops.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4 and even.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launch operation in `op`; sampled only when `busy`=0.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` in WIDTH: rs operand (multiplicand / dividend).
- `b` in WIDTH: rt operand (multiplier / divisor).
- `cancel` in 1: exception flush; aborts the running operation.
- `hi_wr` in 1: mthi; load `wr_data` into HI.
- `lo_wr` in 1: mtlo; load `wr_data` into LO.
- `wr_data` in WIDTH: mthi/mtlo data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse, HI/LO hold the new result.
- `hi` out WIDTH: HI register (mfhi source).
- `lo` out WIDTH: LO register (mflo source).
- `div0` out 1: divide-by-zero flag (see Configuration).

## Operation
- States: IDLE, CALC, FIX. Reset → IDLE; `busy`=0, `done`=0, `div0`=0, `hi`=0, `lo`=0, iteration counter=0.
- IDLE + `start`: latch op; signed ops store |a|, |b| and result sign (mult: sign(a)^sign(b); div: quotient sign(a)^sign(b), remainder sign(a)); unsigned ops use operands as-is. → CALC, counter=0.
- CALC, mult: shift-add over magnitudes, 2·WIDTH-bit accumulator, one multiplier bit per cycle.
- CALC, div: restoring division, one quotient bit per cycle; partial remainder WIDTH+1 bits.
- CALC lasts exactly WIDTH cycles; counter wraps to 0 on exit → FIX.
- FIX: apply two's-complement sign correction; write HI/LO (mult: HI=upper, LO=lower product; div: LO=quotient, HI=remainder); pulse `done`; → IDLE.
- Signed arithmetic: |−2^(WIDTH−1)| held as unsigned WIDTH-bit value; div of −2^(WIDTH−1) by −1 gives LO=−2^(WIDTH−1), HI=0 (wraps, no trap).
- `hi_wr`/`lo_wr` honoured only in IDLE; ignored while `busy`. Same-cycle `hi_wr`/`lo_wr` and `start` in IDLE: move applies now, result overwrites HI/LO at FIX.
- `start` while `busy`: ignored.
- `cancel` in CALC or FIX: → IDLE next edge, HI/LO unchanged, no `done`. `cancel` and `start` together in IDLE: start suppressed.
- `rst` mid-operation: immediate return to reset values.

## Timing
- `start` sampled at edge E0; `busy`=1 from E0 through FIX; CALC at edges E1…E_WIDTH; FIX at E_(WIDTH+1) writes HI/LO and raises `done` for one cycle, `busy`=0 same cycle.
- Latency: HI/LO valid and `done`=1 WIDTH+1 cycles after start edge (33 for WIDTH=32). Back-to-back `start` accepted in the `done` cycle.
- `hi`, `lo` are direct register outputs; mfhi in the `done` cycle reads the new value.

## Configuration
- `MULDIV_DIV0_EXC_EN` defined: div/divu with `b`=0 skips CALC, goes to FIX directly, HI/LO unchanged, `done` pulses 2 cycles after start edge, `div0`=1 for that one cycle.
- Undefined: `div0` tied 0; divide-by-zero runs full WIDTH cycles; result per algorithm on magnitudes: quotient magnitude all-ones, remainder |a|, then normal sign correction.

## Structure
- Package `muldiv_pkg`: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state encodings, iteration counter width $clog2(WIDTH)+1.
- Sub-module `muldiv_step`: combinational single iteration (add-shift or subtract-compare-shift), parametrised by WIDTH.

## Test plan
- WIDTH=32, mult a=0xFFFFFFFD (−3), b=7 → 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` one cycle.
- multu a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- div a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=100, b=7 → LO=14, HI=2; div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu a=5, b=0 → with macro: `done`+`div0` 2 cycles after start, HI/LO unchanged; without: 33 cycles, LO=0xFFFFFFFF, HI=5.
- mthi 0x1234 in IDLE, then mult, `cancel` at cycle 10 → `busy` drops next cycle, no `done`, HI=0x1234; `hi_wr` and `start` while busy ignored.
- Assert `rst` mid-CALC → all outputs zero immediately; fresh mult after release yields correct result.
